probe_conditioner: RTL and testbench

Conditions the raw asynchronous probe pins before they reach the correlator's probe crossbar and correlator pairs.
- Per probe: a multi-flop synchroniser, optional polarity inversion, then a runtime-configurable glitch filter.
- The output vector drives the correlator top-level i_probe bus directly.
- Filtering rejects pulses shorter than the programmed length, so contact bounce and crosstalk do not corrupt correlation metrics.

---
 rtl/probe_conditioner.sv | 73 +++++++
 tb/tb_probe_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/probe_conditioner.sv
// Probe pin conditioner: per-lane synchroniser, polarity invert and glitch filter.
// Define PROBE_CONDITIONER_GLITCHFLAG_EN to add the sticky per-lane glitch flag.
module probe_conditioner #(
  parameter int N_PROBE     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  input  logic [N_PROBE-1:0]  i_probe,
  input  logic [N_PROBE-1:0]  i_invert,
  input  logic [FILTER_W-1:0] i_filterLength,
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
  input  logic [N_PROBE-1:0]  i_glitchClear,
  output logic [N_PROBE-1:0]  o_glitch,
`endif
  output logic [N_PROBE-1:0]  o_probe
);

  logic [N_PROBE-1:0]  sync_q [SYNC_STAGES];
  logic [FILTER_W-1:0] cnt_q  [N_PROBE];
  logic [N_PROBE-1:0]  s;

  // Synchroniser chain; stage 0 is the only flop that sees the raw pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else if (i_cg) begin
      sync_q[0] <= i_probe;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ i_invert;

  // The ">=" lets a shortened filter length release a pending lane immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_probe <= '0;
      for (int i = 0; i < N_PROBE; i++) cnt_q[i] <= '0;
    end else if (i_cg) begin
      for (int i = 0; i < N_PROBE; i++) begin
        if (s[i] == o_probe[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= i_filterLength) begin
          o_probe[i] <= s[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + FILTER_W'(1);
        end
      end
    end
  end

`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
  // An aborted pending transition sets the flag; set beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_glitch <= '0;
    end else if (i_cg) begin
      for (int i = 0; i < N_PROBE; i++) begin
        if ((s[i] == o_probe[i]) && (cnt_q[i] != '0)) begin
          o_glitch[i] <= 1'b1;
        end else if (i_glitchClear[i]) begin
          o_glitch[i] <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_probe_conditioner.sv
// Randomised self-checking bench for probe_conditioner against a run-length reference model.
// Honours PROBE_CONDITIONER_GLITCHFLAG_EN the same way the design does.
module tb_probe_conditioner;

  localparam int N = 4;
  localparam int SYNC = 2;
  localparam int FW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cg;
  logic [N-1:0]  i_probe;
  logic [N-1:0]  i_invert;
  logic [FW-1:0] i_filterLength;
  logic [N-1:0]  o_probe;
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
  logic [N-1:0]  i_glitchClear;
  logic [N-1:0]  o_glitch;
`endif

  int vec_count = 0;
  int miscompare_count = 0;

  // Reference model: delayed samples, output level and consecutive-differ run per lane.
  logic [N-1:0] m_delay [SYNC];
  logic [N-1:0] m_out;
  logic [N-1:0] m_flag;
  int           m_run [N];

  probe_conditioner #(.N_PROBE(N), .SYNC_STAGES(SYNC), .FILTER_W(FW)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cg(i_cg),
    .i_probe(i_probe),
    .i_invert(i_invert),
    .i_filterLength(i_filterLength),
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
    .i_glitchClear(i_glitchClear),
    .o_glitch(o_glitch),
`endif
    .o_probe(o_probe)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] probe, input logic [N-1:0] inv, input int len,
                               input logic cg, input logic rst, input logic [N-1:0] clr);
    i_probe = probe;
    i_invert = inv;
    i_filterLength = FW'(len);
    i_cg = cg;
    i_rst = rst;
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
    i_glitchClear = clr;
`else
    if (clr != clr) $display("[TB] unreachable");
`endif
  endtask

  // A lane's output follows its conditioned input once that input has differed for L+1 enabled edges.
  task automatic modelEdge();
    logic sv;
    if (i_rst) begin
      for (int k = 0; k < SYNC; k++) m_delay[k] = '0;
      m_out = '0;
      m_flag = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else if (i_cg) begin
      for (int i = 0; i < N; i++) begin
        sv = m_delay[SYNC-1][i] ^ i_invert[i];
        if (sv == m_out[i]) begin
          if (m_run[i] > 0) m_flag[i] = 1'b1;
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
          else if (i_glitchClear[i]) m_flag[i] = 1'b0;
`endif
          m_run[i] = 0;
        end else begin
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
          if (i_glitchClear[i]) m_flag[i] = 1'b0;
`endif
          if (m_run[i] >= int'(i_filterLength)) begin
            m_out[i] = sv;
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end
      end
      for (int k = SYNC - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
      m_delay[0] = i_probe;
    end
  endtask

  task automatic stepCycle();
    @(posedge i_clk);
    modelEdge();
    #1;
    checkOutput("probe", o_probe, m_out);
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
    checkOutput("glitch", o_glitch, m_flag);
`endif
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  initial begin
    logic [N-1:0] probe_v;
    logic [N-1:0] inv_v;
    int           len_v;

    for (int k = 0; k < SYNC; k++) m_delay[k] = '0;
    m_out = '0;
    m_flag = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // Reset, honoured even with the clock enable low.
    applyStimulus('0, '0, 0, 1'b0, 1'b1, '0);
    steps(2);
    checkOutput("reset_out", o_probe, 0);

    // L=0: a step on lane 0 lands after the third edge.
    applyStimulus(4'b0001, '0, 0, 1'b1, 1'b0, '0);
    steps(2);
    checkOutput("l0_early", o_probe, 0);
    stepCycle();
    checkOutput("l0_latency", o_probe, 4'b0001);
    applyStimulus('0, '0, 0, 1'b1, 1'b0, '0);
    steps(5);

    // L=3: three-cycle pulse rejected, four-cycle pulse passes.
    applyStimulus(4'b0010, '0, 3, 1'b1, 1'b0, '0);
    steps(3);
    applyStimulus('0, '0, 3, 1'b1, 1'b0, '0);
    steps(8);
    checkOutput("pulse3_rejected", o_probe, 0);
`ifdef PROBE_CONDITIONER_GLITCHFLAG_EN
    checkOutput("pulse3_flag", o_glitch[1], 1);
`endif
    applyStimulus(4'b0010, '0, 3, 1'b1, 1'b0, 4'b0010);
    steps(4);
    applyStimulus('0, '0, 3, 1'b1, 1'b0, '0);
    steps(2);
    checkOutput("pulse4_pass", o_probe[1], 1);
    steps(4);
    checkOutput("pulse4_fall", o_probe[1], 0);

    // Invert change on lane 2 with L=2 rises three edges later.
    applyStimulus('0, 4'b0100, 2, 1'b1, 1'b0, '0);
    steps(2);
    checkOutput("inv_early", o_probe[2], 0);
    stepCycle();
    checkOutput("inv_rise", o_probe[2], 1);

    // Clock-enable freeze mid-count on lane 3 with L=5.
    applyStimulus(4'b1000, 4'b0100, 5, 1'b1, 1'b0, '0);
    steps(4);
    applyStimulus(4'b1000, 4'b0100, 5, 1'b0, 1'b0, '0);
    steps(10);
    checkOutput("cg_frozen", o_probe[3], 0);
    applyStimulus(4'b1000, 4'b0100, 5, 1'b1, 1'b0, '0);
    steps(3);
    checkOutput("cg_pending", o_probe[3], 0);
    stepCycle();
    checkOutput("cg_done", o_probe[3], 1);

    // Filter length shortened mid-count on lane 0.
    applyStimulus(4'b1001, 4'b0100, 7, 1'b1, 1'b0, '0);
    steps(6);
    applyStimulus(4'b1001, 4'b0100, 1, 1'b1, 1'b0, '0);
    stepCycle();
    checkOutput("len_drop", o_probe[0], 1);

    // Reset together with clock enable low.
    applyStimulus(4'b1001, 4'b0100, 1, 1'b0, 1'b1, '0);
    stepCycle();
    checkOutput("rst_cg_low", o_probe, 0);

    // Randomised traffic.
    probe_v = '0;
    inv_v = '0;
    len_v = 2;
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] clr_v;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) probe_v[i] = ~probe_v[i];
      if ($urandom_range(0, 19) == 0) len_v = $urandom_range(0, (1 << FW) - 1);
      if ($urandom_range(0, 49) == 0) inv_v = N'($urandom);
      clr_v = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      applyStimulus(probe_v, inv_v, len_v, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 199) == 0, clr_v);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
